// File: rtl/duft_chain_initiator.sv
// Host-side initiator for one ap_ctrl_chain slave: takes a command, runs one start/done/continue
// handshake, and returns ap_return (or a timeout error) through a single response slot.
module duft_chain_initiator #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic              cmd_rd,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_rd,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] dut_addr,
   output logic [DATA_W-1:0] dut_wr_data,
   output logic              dut_rd_wr,
   output logic              dut_ap_start,
   output logic              dut_ap_continue,
   output logic              dut_ap_ce,
   input  logic              dut_ap_idle,
   input  logic              dut_ap_ready,
   input  logic              dut_ap_done,
   input  logic [DATA_W-1:0] dut_ap_return
);

   // state    | meaning
   // ST_IDLE  | waiting for a command; accepts when slot empty and slave idle
   // ST_START | ap_start high, waiting for done or timeout
   // ST_CONT  | one-cycle ap_continue after a normal completion
   // ST_FLUSH | after timeout: ap_continue held until the slave reports idle
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_CONT, ST_FLUSH} state_t;

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rd_wr_q, rd_wr_d;
   logic              start_q, start_d;
   logic              cont_q, cont_d;
   logic              ce_q, ce_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_rd_q, rsp_rd_d;
   logic              rsp_err_q, rsp_err_d;

   // Gated by the reset pin so the port reads 0 while reset is held.
   assign cmd_ready = ap_rst_n && (state_q == ST_IDLE) && !rsp_valid_q && dut_ap_idle;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_wr_d     = rd_wr_q;
      start_d     = start_q;
      cont_d      = cont_q;
      ce_d        = 1'b1;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_rd_d    = rsp_rd_q;
      rsp_err_d   = rsp_err_q;

      if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               rd_wr_d = cmd_rd;
               start_d = 1'b1;
               cnt_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (dut_ap_done) begin
               rsp_rdata_d = dut_ap_return;
               rsp_rd_d    = rd_wr_q;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               start_d     = 1'b0;
               cont_d      = 1'b1;
               state_d     = ST_CONT;
            end else if ((TIMEOUT != 0) && (cnt_q == TO_VAL)) begin
               rsp_rdata_d = '0;
               rsp_rd_d    = rd_wr_q;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               start_d     = 1'b0;
               cont_d      = 1'b1;
               state_d     = ST_FLUSH;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_CONT: begin
            cont_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_FLUSH: begin
            // A late done from the slave is simply ignored here.
            if (dut_ap_idle) begin
               cont_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            start_d = 1'b0;
            cont_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rd_wr_q     <= 1'b0;
         start_q     <= 1'b0;
         cont_q      <= 1'b0;
         ce_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_rd_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rd_wr_q     <= rd_wr_d;
         start_q     <= start_d;
         cont_q      <= cont_d;
         ce_q        <= ce_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign busy            = (state_q != ST_IDLE);
   assign dut_addr        = addr_q;
   assign dut_wr_data     = wdata_q;
   assign dut_rd_wr       = rd_wr_q;
   assign dut_ap_start    = start_q;
   assign dut_ap_continue = cont_q;
   assign dut_ap_ce       = ce_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_rdata       = rsp_rdata_q;
   assign rsp_rd          = rsp_rd_q;
   assign rsp_err         = rsp_err_q;

   // The slave must never report ready ahead of done while we wait on it.
   a_ready_not_before_done : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      ((state_q == ST_START) && dut_ap_ready) |-> dut_ap_done);

endmodule

// File: tb/tb_duft_chain_initiator.sv
// Directed bench: drives duft_chain_initiator against a small ap_ctrl_chain slave model.
module tb_duft_chain_initiator;
   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        cmd_valid, cmd_ready, cmd_rd;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_rd, rsp_err, busy;
   logic [31:0] rsp_rdata, dut_addr, dut_wr_data;
   logic        dut_rd_wr, dut_ap_start, dut_ap_continue, dut_ap_ce;
   logic        dut_ap_idle, dut_ap_ready, dut_ap_done;
   logic [31:0] dut_ap_return;

   int n_cmp = 0;
   int n_err = 0;
   int cont_cnt = 0;
   logic [31:0] held;

   // slave model controls
   logic        hang = 1'b0;
   logic        hang_release = 1'b0;
   logic        force_busy = 1'b0;
   logic [1:0]  s_state;
   logic [1:0]  s_cnt;
   logic [31:0] mem [0:255];

   always #5 ap_clk = ~ap_clk;

   duft_chain_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_rd(cmd_rd),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_rd(rsp_rd), .rsp_err(rsp_err), .busy(busy),
      .dut_addr(dut_addr), .dut_wr_data(dut_wr_data), .dut_rd_wr(dut_rd_wr),
      .dut_ap_start(dut_ap_start), .dut_ap_continue(dut_ap_continue), .dut_ap_ce(dut_ap_ce),
      .dut_ap_idle(dut_ap_idle), .dut_ap_ready(dut_ap_ready), .dut_ap_done(dut_ap_done),
      .dut_ap_return(dut_ap_return)
   );

   // Slave: 0=idle, 1=running (done after 3 cycles of start), 2=done issued, 3=hung
   assign dut_ap_idle = (s_state == 2'd0) && !force_busy;

   always @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s_state       <= 2'd0;
         s_cnt         <= 2'd0;
         dut_ap_done   <= 1'b0;
         dut_ap_ready  <= 1'b0;
         dut_ap_return <= 32'h0;
      end else begin
         case (s_state)
            2'd0: if (dut_ap_start) begin
               s_state <= hang ? 2'd3 : 2'd1;
               s_cnt   <= 2'd1;
            end
            2'd1: if (s_cnt == 2'd2) begin
               dut_ap_done   <= 1'b1;
               dut_ap_ready  <= 1'b1;
               dut_ap_return <= dut_rd_wr ? mem[dut_addr[7:0]] : 32'h0;
               if (!dut_rd_wr) mem[dut_addr[7:0]] <= dut_wr_data;
               s_state <= 2'd2;
            end else begin
               s_cnt <= s_cnt + 2'd1;
            end
            2'd2: begin
               dut_ap_done  <= 1'b0;
               dut_ap_ready <= 1'b0;
               s_state      <= 2'd0;
            end
            default: if (hang_release) s_state <= 2'd0;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
      if (dut_ap_continue) cont_cnt++;
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      while (!rsp_valid && n < 40) begin
         tick();
         n++;
      end
      chk(tag, (n < 40), 1'b1);
   endtask

   initial begin
      ap_rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_rd = 1'b0;
      rsp_ready = 1'b0;
      #12;
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_ce", dut_ap_ce, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_start", dut_ap_start, 1'b0);
      ap_rst_n = 1'b1;
      tick();
      chk("ce_after_rst", dut_ap_ce, 1'b1);

      // write: accept at cycle 0, start at 1, done at 4, rsp at 5
      cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5_0001; cmd_rd = 1'b0;
      #1;
      chk("wr_cmd_ready", cmd_ready, 1'b1);
      tick(); cmd_valid = 1'b0;
      chk("wr_start_c1", dut_ap_start, 1'b1);
      chk("wr_addr", dut_addr, 32'h10);
      chk("wr_rd_wr_c1", dut_rd_wr, 1'b0);
      chk("wr_busy", busy, 1'b1);
      tick(); tick(); tick();
      chk("wr_no_rsp_c4", rsp_valid, 1'b0);
      tick();
      chk("wr_rsp_c5", rsp_valid, 1'b1);
      chk("wr_err", rsp_err, 1'b0);
      chk("wr_rsp_rd", rsp_rd, 1'b0);
      chk("wr_rd_wr_c5", dut_rd_wr, 1'b0);
      chk("wr_start_drop", dut_ap_start, 1'b0);
      chk("wr_cont_c5", dut_ap_continue, 1'b1);
      rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0;
      chk("wr_rsp_gone", rsp_valid, 1'b0);
      chk("wr_cont_c6", dut_ap_continue, 1'b0);
      chk("wr_idle_ready", cmd_ready, 1'b1);

      // read-back plus 20 cycles of response backpressure
      cont_cnt = 0;
      cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_rd = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick(); tick(); tick(); tick();
      chk("rd_rsp_c5", rsp_valid, 1'b1);
      chk("rd_data", rsp_rdata, 32'hA5A5_0001);
      chk("rd_rsp_rd", rsp_rd, 1'b1);
      held = rsp_rdata;
      cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h0000_1234; cmd_rd = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("bp_valid", rsp_valid, 1'b1);
         chk("bp_data", rsp_rdata, held);
         chk("bp_cmd_ready", cmd_ready, 1'b0);
      end
      chk("rd_single_cont", cont_cnt, 1);
      chk("rd_slave_idle", dut_ap_idle, 1'b1);
      rsp_ready = 1'b1;
      tick();
      chk("bp_release_ready", cmd_ready, 1'b1);
      tick(); cmd_valid = 1'b0;
      chk("bp_next_start", dut_ap_start, 1'b1);
      chk("bp_next_addr", dut_addr, 32'h20);
      wait_rsp("bp_next_rsp");
      tick();

      // timeout with a hung slave
      hang = 1'b1; rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_addr = 32'h30; cmd_rd = 1'b1;
      tick(); cmd_valid = 1'b0;
      chk("to_start", dut_ap_start, 1'b1);
      for (int i = 0; i < 8; i++) tick();
      chk("to_no_rsp_c8", rsp_valid, 1'b0);
      tick();
      chk("to_rsp_c9", rsp_valid, 1'b1);
      chk("to_err", rsp_err, 1'b1);
      chk("to_rdata", rsp_rdata, 32'h0);
      chk("to_start_off", dut_ap_start, 1'b0);
      rsp_ready = 1'b1;
      tick(); tick(); tick();
      chk("to_cont_held", dut_ap_continue, 1'b1);
      chk("to_busy", busy, 1'b1);
      chk("to_no_cmd", cmd_ready, 1'b0);
      hang_release = 1'b1;
      tick(); hang_release = 1'b0; hang = 1'b0;
      chk("to_cont_until_idle", dut_ap_continue, 1'b1);
      tick();
      chk("to_cont_drop", dut_ap_continue, 1'b0);
      chk("to_back_idle", busy, 1'b0);

      // reset during START, then a normal read
      cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_rd = 1'b1;
      tick(); cmd_valid = 1'b0;
      tick();
      chk("mr_in_start", dut_ap_start, 1'b1);
      ap_rst_n = 1'b0;
      #1;
      chk("mr_start", dut_ap_start, 1'b0);
      chk("mr_busy", busy, 1'b0);
      chk("mr_ce", dut_ap_ce, 1'b0);
      chk("mr_cmd_ready", cmd_ready, 1'b0);
      ap_rst_n = 1'b1;
      tick();
      cmd_valid = 1'b1;
      tick(); cmd_valid = 1'b0;
      wait_rsp("mr_read_rsp");
      chk("mr_read_data", rsp_rdata, 32'hA5A5_0001);
      chk("mr_read_err", rsp_err, 1'b0);
      tick();

      // busy slave blocks acceptance
      force_busy = 1'b1;
      cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_rd = 1'b1;
      #1;
      chk("bs_cmd_ready", cmd_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bs_no_start", dut_ap_start, 1'b0);
      end
      force_busy = 1'b0;
      #1;
      chk("bs_ready_back", cmd_ready, 1'b1);
      tick(); cmd_valid = 1'b0;
      chk("bs_start", dut_ap_start, 1'b1);
      wait_rsp("bs_rsp");
      chk("bs_data", rsp_rdata, 32'h0000_1234);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
